clock_monitor_tx: RTL and testbench

//  Drives a divided copy of the core clock onto a monitor pad (user-project IO) so that an

---
 rtl/clock_monitor_tx_pkg.sv | 12 +
 rtl/clock_monitor_tx_if.sv | 28 ++
 rtl/clock_monitor_div.sv | 73 +++++++
 rtl/clock_monitor_tx.sv | 83 ++++++++
 tb/tb_clock_monitor_tx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_monitor_tx_pkg.sv
// Shared clocking definitions for the clock monitor: window FSM encoding and divider floor.
package clock_monitor_tx_pkg;

  localparam int DIV_MIN = 2;

  typedef enum logic [1:0] {
    WIN_IDLE   = 2'd0,
    WIN_ACTIVE = 2'd1,
    WIN_DONE   = 2'd2
  } win_state_e;

endpackage

// File: rtl/clock_monitor_tx_if.sv
// Control/status bundle between the clocking-block controller and the clock monitor.
interface clock_monitor_tx_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
);

  logic             enable;
  logic [DIV_W-1:0] div_value;
  logic             div_load;
  logic             div_ack;
  logic             win_start;
  logic [CNT_W-1:0] win_len;
  logic             clk_out;
  logic             win_active;
  logic             win_done;
  logic [CNT_W-1:0] edge_count;

  modport master (
    output enable, div_value, div_load, win_start, win_len,
    input  div_ack, clk_out, win_active, win_done, edge_count
  );

  modport slave (
    input  enable, div_value, div_load, win_start, win_len,
    output div_ack, clk_out, win_active, win_done, edge_count
  );

endinterface

// File: rtl/clock_monitor_div.sv
// Glitch-free registered clock divider with a pending divisor that only takes effect
// at a period boundary (or while disabled), plus a rise strobe aligned with clk_out going high.
module clock_monitor_div
  import clock_monitor_tx_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_value,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             rise
);

  localparam logic [DIV_W-1:0] N_MIN = DIV_W'(DIV_MIN);

  logic [DIV_W-1:0] phase;
  logic [DIV_W-1:0] n_act;
  logic [DIV_W-1:0] n_pend;
  logic             pend_valid;

  logic             boundary;
  logic             apply;
  logic [DIV_W-1:0] n_pend_eff;
  logic [DIV_W-1:0] n_next;
  logic [DIV_W:0]   hi_cnt;

  // A new period starts whenever the phase counter sits at zero while running;
  // the pending divisor governs that whole new period.
  always_comb begin
    n_pend_eff = (n_pend < N_MIN) ? N_MIN : n_pend;
    boundary   = enable && (phase == '0);
    apply      = pend_valid && (boundary || !enable);
    n_next     = apply ? n_pend_eff : n_act;
    hi_cnt     = ({1'b0, n_next} + (DIV_W+1)'(1)) >> 1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      n_act      <= DIV_W'(DIV_RESET);
      n_pend     <= '0;
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      div_ack    <= 1'b0;
      rise       <= 1'b0;
    end else begin
      div_ack <= apply;
      n_act   <= n_next;
      // A load in the same cycle as a boundary lands after the boundary has used the old pending.
      if (div_load) begin
        n_pend     <= div_value;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
      if (!enable) begin
        phase   <= '0;
        clk_out <= 1'b0;
        rise    <= 1'b0;
      end else begin
        clk_out <= ({1'b0, phase} < hi_cnt);
        rise    <= boundary;
        phase   <= (phase == n_next - DIV_W'(1)) ? '0 : phase + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_monitor_tx.sv
// Clock monitor output: divided clock to the pad plus a measurement window that counts
// clk_out rising edges.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WIN_IDLE   | no window open; edge_count holds the last result
// WIN_ACTIVE | window open, win_active high, counting clk_out rising edges
// WIN_DONE   | window just closed, win_done high for this single cycle
module clock_monitor_tx
  import clock_monitor_tx_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 16,
  parameter int DIV_RESET = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  clock_monitor_tx_if.slave    bus
);

  win_state_e       state;
  win_state_e       state_next;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             rise;

  clock_monitor_div #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .enable    (bus.enable),
    .div_value (bus.div_value),
    .div_load  (bus.div_load),
    .div_ack   (bus.div_ack),
    .clk_out   (bus.clk_out),
    .rise      (rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WIN_IDLE;
      len_q <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      len_q <= len_next;
      count <= count_next;
    end
  end

  // A rise coinciding with win_start is not counted since the FSM is still idle then.
  always_comb begin
    state_next = state;
    len_next   = len_q;
    count_next = count;
    case (state)
      WIN_IDLE: begin
        if (bus.win_start) begin
          len_next   = bus.win_len;
          count_next = '0;
          state_next = (bus.win_len == '0) ? WIN_DONE : WIN_ACTIVE;
        end
      end
      WIN_ACTIVE: begin
        if (rise) begin
          if (count != '1) count_next = count + CNT_W'(1);
          if (count_next == len_q) state_next = WIN_DONE;
        end
      end
      WIN_DONE: state_next = WIN_IDLE;
      default:  state_next = WIN_IDLE;
    endcase
  end

  assign bus.win_active = (state == WIN_ACTIVE);
  assign bus.win_done   = (state == WIN_DONE);
  assign bus.edge_count = count;

endmodule

// File: tb/tb_clock_monitor_tx.sv
// Directed bench for clock_monitor_tx: expected clk_out/div_ack patterns and window
// results are queued as stimulus is applied and checked as the design produces them.
module tb_clock_monitor_tx;

  logic clock = 1'b0;
  logic reset = 1'b1;

  clock_monitor_tx_if #(.DIV_W(8), .CNT_W(16)) bus ();

  clock_monitor_tx #(.DIV_W(8), .CNT_W(16), .DIV_RESET(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] pat_q[$];   // {clk_out, div_ack} per cycle
  int         win_q[$];   // expected edge_count at win_done
  int         act_q[$];   // expected number of win_active cycles

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_period(input int n, input logic ack_first);
    for (int k = 0; k < n; k++)
      pat_q.push_back({(k < (n + 1) / 2) ? 1'b1 : 1'b0, (k == 0) ? ack_first : 1'b0});
  endtask

  task automatic run_pattern(input string tag, input int n, input int load_at,
                             input logic [7:0] load_val);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      tick;
      bus.div_load = 1'b0;
      if (pat_q.size() == 0) begin
        check({tag, " pattern underrun"}, 32'd1, 32'd0);
      end else begin
        e = pat_q.pop_front();
        check({tag, " clk_out"}, bus.clk_out, e[1]);
        check({tag, " div_ack"}, bus.div_ack, e[0]);
      end
      if (i == load_at) begin
        bus.div_value = load_val;
        bus.div_load  = 1'b1;
      end
    end
  endtask

  task automatic set_div_disabled(input logic [7:0] val);
    bus.enable    = 1'b0;
    bus.div_value = val;
    bus.div_load  = 1'b1;
    tick;
    bus.div_load = 1'b0;
    tick;
    check("disabled load div_ack", bus.div_ack, 1);
    check("disabled clk_out", bus.clk_out, 0);
    bus.enable = 1'b1;
  endtask

  task automatic wait_rise;
    logic prev;
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      prev = bus.clk_out;
      tick;
      if (prev == 1'b0 && bus.clk_out == 1'b1) ok = 1'b1;
    end
    check("wait_rise timeout", ok, 1);
  endtask

  // Called at a cycle where clk_out has just risen; that rise must not be counted.
  task automatic run_window(input string tag, input int len, input int n_div,
                            input int extra_at, input int budget);
    int active;
    int dones;
    int exp_cnt;
    active = 0;
    dones  = 0;
    exp_cnt = len;
    bus.win_start = 1'b1;
    bus.win_len   = 16'(len);
    win_q.push_back(len);
    act_q.push_back(len * n_div);
    for (int i = 0; i < budget; i++) begin
      tick;
      bus.win_start = 1'b0;
      if (bus.win_active) active++;
      if (bus.win_done) begin
        dones++;
        if (win_q.size() > 0) exp_cnt = win_q.pop_front();
        check({tag, " edge_count at done"}, bus.edge_count, exp_cnt);
        check({tag, " active low at done"}, bus.win_active, 0);
      end
      if (i == extra_at) begin
        bus.win_start = 1'b1;
        bus.win_len   = 16'd1;
      end
    end
    check({tag, " win_done pulses"}, dones, 1);
    check({tag, " active cycles"}, active, (act_q.size() > 0) ? act_q.pop_front() : -1);
    check({tag, " edge_count holds"}, bus.edge_count, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.enable    = 1'b0;
    bus.div_value = '0;
    bus.div_load  = 1'b0;
    bus.win_start = 1'b0;
    bus.win_len   = '0;

    // reset state
    tick;
    tick;
    check("reset clk_out", bus.clk_out, 0);
    check("reset div_ack", bus.div_ack, 0);
    check("reset win_active", bus.win_active, 0);
    check("reset win_done", bus.win_done, 0);
    check("reset edge_count", bus.edge_count, 0);

    // N=2 after reset: toggles every cycle, 10 rising edges in 20 cycles
    reset      = 1'b0;
    bus.enable = 1'b1;
    for (int p = 0; p < 10; p++) push_period(2, 1'b0);
    run_pattern("n2", 20, -1, 8'd0);

    // N=5, then a mid-period load of 4 acked at the next rising edge
    set_div_disabled(8'd5);
    push_period(5, 1'b0);
    push_period(5, 1'b0);
    push_period(4, 1'b1);
    push_period(4, 1'b0);
    run_pattern("n5to4", 18, 6, 8'd4);

    // load 6 coincident with a boundary, then 8 overwrites it: one ack, N=8
    bus.div_value = 8'd6;
    bus.div_load  = 1'b1;
    push_period(4, 1'b0);
    push_period(8, 1'b1);
    push_period(8, 1'b0);
    run_pattern("n6then8", 20, 0, 8'd8);

    // N=4 window of 10 edges
    set_div_disabled(8'd4);
    wait_rise;
    run_window("win10", 10, 4, -1, 50);

    // zero-length window
    bus.win_start = 1'b1;
    bus.win_len   = 16'd0;
    tick;
    bus.win_start = 1'b0;
    check("len0 win_done", bus.win_done, 1);
    check("len0 win_active", bus.win_active, 0);
    tick;
    check("len0 win_done cleared", bus.win_done, 0);
    check("len0 win_active after", bus.win_active, 0);

    // win_start during ACTIVE is ignored
    wait_rise;
    run_window("win3", 3, 4, 4, 20);

    // reset mid-window, mid-period
    wait_rise;
    bus.win_start = 1'b1;
    bus.win_len   = 16'd10;
    tick;
    bus.win_start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check("pre-reset win_active", bus.win_active, 1);
    check("pre-reset edge_count", bus.edge_count, 1);
    check("pre-reset clk_out", bus.clk_out, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset clk_out", bus.clk_out, 0);
    check("async reset div_ack", bus.div_ack, 0);
    check("async reset win_active", bus.win_active, 0);
    check("async reset win_done", bus.win_done, 0);
    check("async reset edge_count", bus.edge_count, 0);
    tick;
    tick;
    reset = 1'b0;
    for (int p = 0; p < 4; p++) push_period(2, 1'b0);
    run_pattern("post-reset n2", 8, -1, 8'd0);
    check("post-reset win_active", bus.win_active, 0);
    check("post-reset edge_count", bus.edge_count, 0);

    // divisor 1 and 0 behave as 2
    set_div_disabled(8'd1);
    push_period(2, 1'b0);
    push_period(2, 1'b0);
    run_pattern("n1", 4, -1, 8'd0);
    set_div_disabled(8'd0);
    push_period(2, 1'b0);
    push_period(2, 1'b0);
    run_pattern("n0", 4, -1, 8'd0);

    check("pattern queue drained", pat_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
